// File: rtl/codec_i2c_pkg.sv
// Shared types and constants for the codec I2C scheduler: FSM encoding,
// default parameters and the codec power-up register table.
package codec_i2c_pkg;

    localparam int DEFAULT_INIT_LEN       = 10;
    localparam int DEFAULT_MAX_RETRIES    = 3;
    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;
    localparam int IDX_W                  = 4;

    typedef enum logic [2:0] {
        IDLE,
        INIT_ISSUE,
        INIT_WAIT,
        SRV_ISSUE,
        SRV_WAIT,
        ACK
    } state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } init_entry_t;

    // Power-up order: reset, power, line-in, headphone, paths, format, activate.
    function automatic init_entry_t init_entry(input logic [IDX_W-1:0] idx);
        init_entry_t e;
        case (idx)
            4'd0:    e = '{addr: 7'h0F, data: 9'h000};
            4'd1:    e = '{addr: 7'h06, data: 9'h010};
            4'd2:    e = '{addr: 7'h00, data: 9'h017};
            4'd3:    e = '{addr: 7'h01, data: 9'h017};
            4'd4:    e = '{addr: 7'h02, data: 9'h079};
            4'd5:    e = '{addr: 7'h03, data: 9'h079};
            4'd6:    e = '{addr: 7'h04, data: 9'h012};
            4'd7:    e = '{addr: 7'h05, data: 9'h000};
            4'd8:    e = '{addr: 7'h07, data: 9'h00A};
            4'd9:    e = '{addr: 7'h09, data: 9'h001};
            default: e = '{addr: 7'h09, data: 9'h001};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/i2c_xfer_timer.sv
// Per-transfer watchdog and retry bookkeeping: counts cycles since the last
// start and how many re-issues the current transfer has consumed.
module i2c_xfer_timer
    import codec_i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = DEFAULT_MAX_RETRIES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    input  logic retry_clr,
    input  logic retry_inc,
    output logic timeout,
    output logic exhausted
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic [CNT_W-1:0] cnt;
    logic [RTY_W-1:0] retries;

    // cnt equals the number of cycles elapsed since the start pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(1);
        end else if (run) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || retry_clr) begin
            retries <= '0;
        end else if (retry_inc && !exhausted) begin
            retries <= retries + RTY_W'(1);
        end
    end

    assign timeout   = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign exhausted = (retries == RTY_W'(MAX_RETRIES));

endmodule

// File: rtl/codec_i2c_scheduler.sv
// Sequences the codec init table over an I2C master, then serves host
// register writes/reads one at a time with NACK/timeout retry.
module codec_i2c_scheduler
    import codec_i2c_pkg::*;
#(
    parameter int INIT_LEN       = DEFAULT_INIT_LEN,
    parameter int MAX_RETRIES    = DEFAULT_MAX_RETRIES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_wr_req,
    input  logic        reg_rd_req,
    input  logic [31:0] reg_addr,
    input  logic [31:0] reg_wr_data,
    output logic        clear_wr,
    output logic        clear_rd,
    output logic        busy,
    output logic        init_done,
    output logic        missed_ack,
    output logic [31:0] rd_data,
    output logic        rd_update,
    output logic        i2c_start,
    output logic        i2c_rnw,
    output logic [6:0]  i2c_addr,
    output logic [8:0]  i2c_wdata,
    input  logic        i2c_ready,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    input  logic [8:0]  i2c_rdata,
    output state_t      dbg_state
);

    state_t            state, state_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic              init_done_d, missed_ack_d;
    logic              load_srv, srv_rnw_d, load_rd, rd_pulse;
    logic [6:0]        lat_addr;
    logic [8:0]        lat_wdata;
    logic              lat_rnw;
    logic              armed, in_issue, in_wait, in_init;
    logic              xfer_ok, xfer_fail, retry_inc, retry_clr;
    logic              timeout, exhausted;
    init_entry_t       cur_entry;
    logic              unused_bits;

    assign unused_bits = ^{reg_addr[31:7], reg_wr_data[31:9]};
    assign cur_entry   = init_entry(idx);
    assign in_issue    = (state == INIT_ISSUE) || (state == SRV_ISSUE);
    assign in_wait     = (state == INIT_WAIT) || (state == SRV_WAIT);
    assign in_init     = (state == INIT_ISSUE) || (state == INIT_WAIT);

    // Master handshake: i2c_start fires only while i2c_ready is high and only
    // after ready was already seen the cycle before (armed); i2c_done/i2c_nack/
    // i2c_rdata are one-cycle and are honoured only in the *_WAIT states.
    assign i2c_start = !reset && in_issue && armed && i2c_ready;
    assign xfer_ok   = in_wait && i2c_done && !i2c_nack;
    assign xfer_fail = in_wait && (i2c_done ? i2c_nack : timeout);

    i2c_xfer_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (i2c_start),
        .run       (in_wait),
        .retry_clr (retry_clr),
        .retry_inc (retry_inc),
        .timeout   (timeout),
        .exhausted (exhausted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT_ISSUE;
            idx        <= '0;
            init_done  <= 1'b0;
            missed_ack <= 1'b0;
            rd_data    <= '0;
            rd_pulse   <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_rnw    <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            init_done  <= init_done_d;
            missed_ack <= missed_ack_d;
            rd_pulse   <= load_rd;
            armed      <= in_issue && i2c_ready && !i2c_start;
            if (load_srv) begin
                lat_addr  <= reg_addr[6:0];
                lat_wdata <= srv_rnw_d ? 9'h000 : reg_wr_data[8:0];
                lat_rnw   <= srv_rnw_d;
            end
            if (load_rd) begin
                rd_data <= {23'h0, i2c_rdata};
            end
        end
    end

    always_comb begin
        state_d      = state;
        idx_d        = idx;
        init_done_d  = init_done;
        missed_ack_d = missed_ack;
        load_srv     = 1'b0;
        srv_rnw_d    = 1'b0;
        load_rd      = 1'b0;
        retry_inc    = 1'b0;
        retry_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (init_done && reg_wr_req) begin
                    load_srv = 1'b1;
                    state_d  = SRV_ISSUE;
                end else if (init_done && reg_rd_req) begin
                    load_srv  = 1'b1;
                    srv_rnw_d = 1'b1;
                    state_d   = SRV_ISSUE;
                end
            end
            INIT_ISSUE: if (i2c_start) state_d = INIT_WAIT;
            SRV_ISSUE:  if (i2c_start) state_d = SRV_WAIT;
            INIT_WAIT: begin
                // An abandoned init entry still advances the table.
                if (xfer_ok || (xfer_fail && exhausted)) begin
                    retry_clr    = 1'b1;
                    missed_ack_d = missed_ack || !xfer_ok;
                    if (idx == IDX_W'(INIT_LEN - 1)) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        state_d = INIT_ISSUE;
                    end
                end else if (xfer_fail) begin
                    retry_inc = 1'b1;
                    state_d   = INIT_ISSUE;
                end
            end
            SRV_WAIT: begin
                if (xfer_ok) begin
                    retry_clr = 1'b1;
                    load_rd   = lat_rnw;
                    state_d   = ACK;
                end else if (xfer_fail && exhausted) begin
                    retry_clr    = 1'b1;
                    missed_ack_d = 1'b1;
                    state_d      = ACK;
                end else if (xfer_fail) begin
                    retry_inc = 1'b1;
                    state_d   = SRV_ISSUE;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = INIT_ISSUE;
        endcase
    end

    assign busy      = reset || (state != IDLE);
    assign clear_wr  = !reset && (state == ACK) && !lat_rnw;
    assign clear_rd  = !reset && (state == ACK) && lat_rnw;
    assign rd_update = !reset && rd_pulse;
    assign i2c_rnw   = in_init ? 1'b0 : lat_rnw;
    assign i2c_addr  = in_init ? cur_entry.addr : lat_addr;
    assign i2c_wdata = in_init ? cur_entry.data : lat_wdata;
    assign dbg_state = state;

endmodule

// File: tb/tb_codec_i2c_scheduler.sv
// Directed bench for codec_i2c_scheduler: init sequencing, host write/read
// vectors, NACK retry, timeout abandon and reset during a host transfer.
module tb_codec_i2c_scheduler;
    import codec_i2c_pkg::*;

    localparam int TCY = 16;
    localparam int W   = 17;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        reg_wr_req = 1'b0, reg_rd_req = 1'b0;
    logic [31:0] reg_addr = '0, reg_wr_data = '0;
    logic        clear_wr, clear_rd, busy, init_done, missed_ack, rd_update;
    logic [31:0] rd_data;
    logic        i2c_start, i2c_rnw;
    logic [6:0]  i2c_addr;
    logic [8:0]  i2c_wdata;
    logic        i2c_ready = 1'b1, i2c_done = 1'b0, i2c_nack = 1'b0;
    logic [8:0]  i2c_rdata = '0;
    state_t      dbg_state;

    codec_i2c_scheduler #(.INIT_LEN(10), .MAX_RETRIES(3), .TIMEOUT_CYCLES(TCY)) dut (
        .clk(clk), .reset(reset), .reg_wr_req(reg_wr_req), .reg_rd_req(reg_rd_req),
        .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .clear_wr(clear_wr),
        .clear_rd(clear_rd), .busy(busy), .init_done(init_done), .missed_ack(missed_ack),
        .rd_data(rd_data), .rd_update(rd_update), .i2c_start(i2c_start), .i2c_rnw(i2c_rnw),
        .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_ready(i2c_ready),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata), .dbg_state(dbg_state)
    );

    logic [6:0] tbl_addr [10] = '{7'h0F, 7'h06, 7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h07, 7'h09};
    logic [8:0] tbl_data [10] = '{9'h000, 9'h010, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012, 9'h000, 9'h00A, 9'h001};

    // scoreboard and monitors
    logic [W-1:0] exp_q[$];
    int checks = 0, errors = 0, cycle = 0;
    int n_start = 0, n_clr_wr = 0, n_clr_rd = 0, n_upd = 0, n_not_ready = 0, last_clr_cyc = 0;
    int start_cyc[$];

    // master model
    int         pend = 0, nack_left = 0;
    logic       withhold = 1'b0, m_nack_next = 1'b0;
    logic [6:0] nack_addr = '0;
    logic [8:0] m_rdata = '0;

    typedef struct {
        logic wr; logic rd; logic [6:0] addr; logic [8:0] wdata; logic [8:0] rdata;
        int ready_low; logic scramble;
        logic exp_rnw; logic [6:0] exp_addr; logic [8:0] exp_wdata;
        logic exp_upd; logic [31:0] exp_rd_data; logic exp_rd_pend;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then update inputs.
    task automatic step();
        logic [W-1:0] got;
        @(negedge clk);
        cycle++;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        if (reset) begin
            pend = 0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                i2c_done  = 1'b1;
                i2c_nack  = m_nack_next;
                i2c_rdata = m_rdata;
            end
        end
        if (i2c_start) begin
            n_start++;
            start_cyc.push_back(cycle);
            if (!i2c_ready) n_not_ready++;
            got = {i2c_rnw, i2c_addr, i2c_wdata};
            check("start_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) check("xfer", 32'(got), 32'(exp_q.pop_front()));
            m_nack_next = (nack_left > 0) && (i2c_addr == nack_addr) && !i2c_rnw;
            if (m_nack_next) nack_left--;
            if (!withhold) pend = 2;
        end
        if (clear_wr) begin n_clr_wr++; last_clr_cyc = cycle; reg_wr_req = 1'b0; end
        if (clear_rd) begin n_clr_rd++; last_clr_cyc = cycle; reg_rd_req = 1'b0; end
        if (rd_update) n_upd++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        exp_q.delete();
        repeat (n) step();
        check("rst_state", 32'(dbg_state), 32'(INIT_ISSUE));
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_init_done", 32'(init_done), 32'(0));
        check("rst_missed_ack", 32'(missed_ack), 32'(0));
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_pulses", 32'({clear_wr, clear_rd, rd_update, i2c_start}), 32'(0));
        reset = 1'b0;
    endtask

    task automatic push_init(input int nack_idx, input int nack_times);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({1'b0, tbl_addr[i], tbl_data[i]});
            if (i == nack_idx)
                for (int j = 0; j < nack_times; j++) exp_q.push_back({1'b0, tbl_addr[i], tbl_data[i]});
        end
    endtask

    task automatic wait_init(input string name);
        logic hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            step();
            if (init_done) hit = 1'b1;
        end
        check({name, "_init_done"}, 32'(hit), 32'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   s0, c_wr0, c_rd0, u0, base;
        logic hit;
        vec_t v;
        //          wr    rd    addr   wdata   rdata  rl scr rnw  eaddr  ewdata  upd  rd_data        pend
        vecs[0] = '{1'b1, 1'b0, 7'h04, 9'h012, 9'h000, 0, 1'b0, 1'b0, 7'h04, 9'h012, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 7'h07, 9'h1FF, 9'h000, 0, 1'b1, 1'b0, 7'h07, 9'h1FF, 1'b0, 32'h0000_0000, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 7'h0A, 9'h055, 9'h1A5, 0, 1'b0, 1'b0, 7'h0A, 9'h055, 1'b0, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 7'h0A, 9'h000, 9'h1A5, 0, 1'b0, 1'b1, 7'h0A, 9'h000, 1'b1, 32'h0000_01A5, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 7'h7F, 9'h000, 9'h000, 0, 1'b0, 1'b1, 7'h7F, 9'h000, 1'b1, 32'h0000_0000, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 7'h01, 9'h000, 9'h1FF, 0, 1'b0, 1'b1, 7'h01, 9'h000, 1'b1, 32'h0000_01FF, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 7'h00, 9'h000, 9'h000, 5, 1'b0, 1'b0, 7'h00, 9'h000, 1'b0, 32'h0000_01FF, 1'b0};

        // power-up init, every entry acknowledged
        do_reset(3);
        push_init(-1, 0);
        wait_init("init");
        check("init_q_empty", 32'(exp_q.size()), 32'(0));
        check("init_busy", 32'(busy), 32'(0));
        check("init_missed", 32'(missed_ack), 32'(0));
        check("init_starts", 32'(n_start), 32'(10));

        // host vectors
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            if (v.wr) begin
                reg_wr_req  = 1'b1;
                reg_addr    = 32'hFFFF_FF80 | 32'(v.addr);
                reg_wr_data = 32'hFFFF_FE00 | 32'(v.wdata);
            end
            if (v.rd) begin
                reg_rd_req = 1'b1;
                if (!v.wr) reg_addr = 32'h1234_5600 | 32'(v.addr);
            end
            m_rdata = v.rdata;
            if (v.ready_low > 0) i2c_ready = 1'b0;
            exp_q.push_back({v.exp_rnw, v.exp_addr, v.exp_wdata});
            s0 = n_start; c_wr0 = n_clr_wr; c_rd0 = n_clr_rd; u0 = n_upd;
            hit = 1'b0;
            for (int k = 0; k < 60 && !hit; k++) begin
                if (k == v.ready_low) i2c_ready = 1'b1;
                step();
                if (v.scramble && n_start != s0 && dbg_state == SRV_WAIT) begin
                    reg_addr    = $urandom;
                    reg_wr_data = $urandom;
                end
                if (clear_wr || clear_rd) hit = 1'b1;
            end
            check($sformatf("v%0d_ack_seen", i), 32'(hit), 32'(1));
            check($sformatf("v%0d_addr_held", i), 32'(i2c_addr), 32'(v.exp_addr));
            check($sformatf("v%0d_wdata_held", i), 32'(i2c_wdata), 32'(v.exp_wdata));
            check($sformatf("v%0d_rnw", i), 32'(i2c_rnw), 32'(v.exp_rnw));
            check($sformatf("v%0d_rd_update", i), 32'(rd_update), 32'(v.exp_upd));
            check($sformatf("v%0d_rd_data", i), rd_data, v.exp_rd_data);
            step();
            check($sformatf("v%0d_busy_idle", i), 32'(busy), 32'(0));
            check($sformatf("v%0d_clr_wr_cnt", i), 32'(n_clr_wr - c_wr0), 32'(!v.exp_rnw));
            check($sformatf("v%0d_clr_rd_cnt", i), 32'(n_clr_rd - c_rd0), 32'(v.exp_rnw));
            check($sformatf("v%0d_upd_cnt", i), 32'(n_upd - u0), 32'(v.exp_upd));
            check($sformatf("v%0d_rd_pending", i), 32'(reg_rd_req), 32'(v.exp_rd_pend));
        end
        check("host_q_empty", 32'(exp_q.size()), 32'(0));

        // host read with done withheld: 4 attempts, each timed out after 15 cycles
        withhold = 1'b1;
        reg_rd_req = 1'b1;
        reg_addr   = 32'h0000_000B;
        for (int j = 0; j < 4; j++) exp_q.push_back({1'b1, 7'h0B, 9'h000});
        s0 = n_start; u0 = n_upd; base = start_cyc.size();
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            step();
            if (clear_rd) hit = 1'b1;
        end
        check("to_clear_rd", 32'(hit), 32'(1));
        check("to_starts", 32'(n_start - s0), 32'(4));
        if (n_start - s0 >= 4) begin
            for (int j = 0; j < 3; j++)
                check($sformatf("to_spacing%0d", j), 32'(start_cyc[base+j+1] - start_cyc[base+j]), 32'(17));
            check("to_abandon_delay", 32'(last_clr_cyc - start_cyc[base+3]), 32'(16));
        end
        check("to_missed_ack", 32'(missed_ack), 32'(1));
        check("to_no_update", 32'(n_upd - u0), 32'(0));
        check("to_rd_data_kept", rd_data, 32'h0000_01FF);
        withhold = 1'b0;
        step();
        check("to_busy_idle", 32'(busy), 32'(0));

        // NACK four times on init entry 2
        do_reset(2);
        nack_addr = 7'h00;
        nack_left = 4;
        s0 = n_start;
        push_init(2, 3);
        wait_init("nack");
        check("nack_starts", 32'(n_start - s0), 32'(13));
        check("nack_all_used", 32'(nack_left), 32'(0));
        check("nack_missed_ack", 32'(missed_ack), 32'(1));
        check("nack_q_empty", 32'(exp_q.size()), 32'(0));
        check("nack_busy", 32'(busy), 32'(0));

        // reset while a host write waits for the master
        reg_wr_req  = 1'b1;
        reg_addr    = 32'h0000_0002;
        reg_wr_data = 32'h0000_00AA;
        exp_q.push_back({1'b0, 7'h02, 9'h0AA});
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step();
            if (dbg_state == SRV_WAIT) hit = 1'b1;
        end
        check("rm_reached_wait", 32'(hit), 32'(1));
        c_wr0 = n_clr_wr;
        do_reset(2);
        check("rm_no_clear_in_reset", 32'(n_clr_wr - c_wr0), 32'(0));
        push_init(-1, 0);
        exp_q.push_back({1'b0, 7'h02, 9'h0AA});
        wait_init("rm");
        check("rm_no_clear_in_init", 32'(n_clr_wr - c_wr0), 32'(0));
        check("rm_req_pending", 32'(reg_wr_req), 32'(1));
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step();
            if (clear_wr) hit = 1'b1;
        end
        check("rm_served", 32'(hit), 32'(1));
        check("rm_q_empty", 32'(exp_q.size()), 32'(0));
        check("rm_missed_ack", 32'(missed_ack), 32'(0));

        check("start_while_not_ready", 32'(n_not_ready), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/codec_i2c_scheduler.md
CODEC_I2C_SCHEDULER -- requirements
Module: codec_i2c_scheduler

Interface
REQ-001 SHALL have parameter INIT_LEN, default 10, number of entries in the codec init table.
REQ-002 SHALL have parameter MAX_RETRIES, default 3, number of re-issues after a NACK or timeout before the transfer is abandoned.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, limit in cycles from i2c_start to i2c_done.
REQ-004 SHALL have these ports:
- clk  in  1  single clock; one clock, reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- reg_wr_req  in  1  level; host write requested (REG_i2c_data_wr).
- reg_rd_req  in  1  level; host read requested (REG_i2c_data_rd).
- reg_addr  in  32  host codec register address; [6:0] used.
- reg_wr_data  in  32  host write data; [8:0] used.
- clear_wr  out  1  one-cycle pulse, clears the host write request.
- clear_rd  out  1  one-cycle pulse, clears the host read request.
- busy  out  1  a transfer or the init sequence is in progress.
- init_done  out  1  sticky; init table completed.
- missed_ack  out  1  sticky; a transfer was abandoned.
- rd_data  out  32  last read result, zero-extended.
- rd_update  out  1  one-cycle pulse when rd_data is loaded.
- i2c_start  out  1  one-cycle command to the I2C master.
- i2c_rnw  out  1  1 = read, 0 = write.
- i2c_addr  out  7  codec register address.
- i2c_wdata  out  9  codec write data.
- i2c_ready  in  1  master idle.
- i2c_done  in  1  one-cycle transfer complete.
- i2c_nack  in  1  valid with i2c_done; NACK received.
- i2c_rdata  in  9  valid with i2c_done.

Function
REQ-005 SHALL implement the FSM IDLE, INIT_ISSUE, INIT_WAIT, SRV_ISSUE, SRV_WAIT, ACK.
REQ-006 SHALL go from reset to INIT_ISSUE, which waits for i2c_ready and then pulses i2c_start with table entry idx (i2c_rnw=0).
REQ-007 SHALL, in INIT_WAIT on i2c_done with i2c_nack=0, increment idx; at idx=INIT_LEN-1 it sets init_done and goes to IDLE, otherwise it returns to INIT_ISSUE.
REQ-008 SHALL ignore host requests before init_done and leave them pending, not cleared.
REQ-009 SHALL, in IDLE with init_done=1, service reg_wr_req first (i2c_rnw=0), then reg_rd_req (i2c_rnw=1, i2c_wdata=0).
REQ-010 SHALL serve one request per pass when wr and rd are simultaneous: write first, read on the next IDLE pass.
REQ-011 SHALL latch i2c_addr and i2c_wdata on entry to SRV_ISSUE and hold them stable until ACK, even if reg_* inputs change.
REQ-012 SHALL, on a successful read, load rd_data={23'h0,i2c_rdata} and pulse rd_update in the same cycle as the ACK state.
REQ-013 SHALL, in ACK, pulse clear_wr or clear_rd (matching the served request) for exactly one cycle and return to IDLE the next cycle.
REQ-014 SHALL treat a NACK, or the timeout counter reaching TIMEOUT_CYCLES-1 without i2c_done, as a failure; the failure re-enters *_ISSUE and increments the retry counter.
REQ-015 SHALL, once the retry counter equals MAX_RETRIES, set missed_ack and abandon the transfer: init advances idx, host requests go to ACK (clear pulsed, no rd_update).
REQ-016 SHALL reset the timeout counter at each i2c_start and the retry counter at each new transfer.
REQ-017 SHALL drive busy=1 in every state except IDLE.
REQ-018 SHALL ignore i2c_done outside the *_WAIT states.
REQ-019 SHALL make i2c_start latency at least 1 cycle after i2c_ready is seen in *_ISSUE, and SHALL never assert i2c_start while i2c_ready=0.

Reset
REQ-020 SHALL, on reset, force state=INIT_ISSUE, idx=0, retry counter=0, timeout counter=0, init_done=0, missed_ack=0, rd_data=0, and busy=1.
REQ-021 SHALL hold all pulse outputs (clear_wr, clear_rd, rd_update, i2c_start) at 0 during reset.
REQ-022 SHALL, when reset is asserted mid-transfer, abort immediately and restart the init sequence from idx 0, with no clear pulse.

Structure
REQ-023 SHALL place the state enum, the codec init table (INIT_LEN entries of {7-bit addr, 9-bit data}) and the default constants in package codec_i2c_pkg.
REQ-024 SHALL use one sub-module, i2c_xfer_timer, for the timeout and retry counters with timeout/exhausted flags; the FSM stays in the top module.

Verification
REQ-025 SHALL include a bench case: reset, master ACKs every transfer -> 10 writes match the table in order, then init_done=1, busy=0.
REQ-026 SHALL include a bench case: after init, reg_wr_req with addr 0x04, data 0x012 -> i2c_addr=0x04, i2c_wdata=0x012, rnw=0, one clear_wr pulse, reg_rd_req untouched.
REQ-027 SHALL include a bench case: reg_wr_req and reg_rd_req both asserted -> write issued first; read next returns i2c_rdata=0x1A5, giving rd_data=0x000001A5 with rd_update, then clear_rd.
REQ-028 SHALL include a bench case: master NACKs 4 times on init entry 2 -> 4 i2c_start pulses, missed_ack=1, entry 3 follows, init_done still reached.
REQ-029 SHALL include a bench case: i2c_done withheld with TIMEOUT_CYCLES=16 -> re-issue 16 cycles after each start; abandoned after 3 retries.
REQ-030 SHALL include a bench case: reset asserted during SRV_WAIT -> no clear pulse, init restarts at idx 0, pending host request served after init_done.
